serial_add_ctrl: RTL and testbench

Multi-cycle sequencer that performs wide (SLICE_W*NUM_SLICES-bit) add/subtract by time-multiplexing one external SLICE_W-bit carry-propagate adder slice, least-significant slice first.
- Owns the operand/result registers and the inter-slice carry register.
- Drives the slice adder's inputs and captures its combinational outputs.
- Presents valid/ready request and response handshakes to the issuing unit.

---
 rtl/serial_add_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: performs a wide add or subtract by sending one SLICE_W-bit
// slice per cycle through an external carry-propagate adder. The least
// significant slice goes first. The operand, result and inter-slice carry
// registers are kept here. Requests and responses use valid/ready handshakes.
`timescale 1ns/1ps

module serial_add_ctrl #(
   parameter int SLICE_W    = 8,
   parameter int NUM_SLICES = 4,
   localparam int W         = SLICE_W * NUM_SLICES,
   localparam int IDX_W     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [W-1:0]       req_a,
   input  logic [W-1:0]       req_b,
   input  logic               req_cin,
   input  logic               req_sub,
   output logic [SLICE_W-1:0] add_a,
   output logic [SLICE_W-1:0] add_b,
   output logic               add_cin,
   input  logic [SLICE_W-1:0] add_s,
   input  logic               add_cout,
   output logic               busy,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [W-1:0]       rsp_sum,
   output logic               rsp_cout,
   output logic               rsp_ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               carry_q, carry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               rspCout_q, rspCout_d;
   logic               rspOvf_q, rspOvf_d;

   logic [SLICE_W-1:0] aSlice;
   logic [SLICE_W-1:0] bSlice;
   logic               lastSlice;

   // The slice under work is chosen by the index. B is already inverted for a subtract.
   assign aSlice    = a_q[idx_q*SLICE_W +: SLICE_W];
   assign bSlice    = b_q[idx_q*SLICE_W +: SLICE_W];
   assign lastSlice = (idx_q == IDX_W'(NUM_SLICES - 1));

   // The adder inputs are driven only while a run is in progress. They are zero at all other times.
   assign add_a   = (state_q == RUN) ? aSlice  : '0;
   assign add_b   = (state_q == RUN) ? bSlice  : '0;
   assign add_cin = (state_q == RUN) ? carry_q : 1'b0;

   // The handshake and status flags come straight from the state.
   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign rsp_valid = (state_q == DONE);
   assign rsp_sum   = sum_q;
   assign rsp_cout  = rspCout_q;
   assign rsp_ovf   = rspOvf_q;

   // State register. Reset aborts any operation in flight and discards the operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         idx_q     <= '0;
         rspCout_q <= 1'b0;
         rspOvf_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         idx_q     <= idx_d;
         rspCout_q <= rspCout_d;
         rspOvf_q  <= rspOvf_d;
      end
   end

   // Next-state logic: accept in IDLE, capture one slice per cycle in RUN, wait for the consumer in DONE.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      idx_d     = idx_q;
      rspCout_d = rspCout_q;
      rspOvf_d  = rspOvf_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_sub ? ~req_b : req_b;
               carry_d = req_sub ? 1'b1 : req_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*SLICE_W +: SLICE_W] = add_s;
            carry_d = add_cout;
            if (lastSlice) begin
               idx_d     = '0;
               state_d   = DONE;
               rspCout_d = add_cout;
               rspOvf_d  = (a_q[W-1] == b_q[W-1]) && (add_s[SLICE_W-1] != a_q[W-1]);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl. A behavioural
// slice adder sits in the bench, and a cycle-level reference model is built from
// whole-word arithmetic. Directed vectors pin the model with literal results.
// Random operations then exercise the model further.
`timescale 1ns/1ps

module tb_serial_add_ctrl;

   localparam int SLICE_W    = 8;
   localparam int NUM_SLICES = 4;
   localparam int W          = SLICE_W * NUM_SLICES;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [W-1:0]       req_a = '0;
   logic [W-1:0]       req_b = '0;
   logic               req_cin = 1'b0;
   logic               req_sub = 1'b0;
   logic [SLICE_W-1:0] add_a;
   logic [SLICE_W-1:0] add_b;
   logic               add_cin;
   logic [SLICE_W-1:0] add_s;
   logic               add_cout;
   logic               busy;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [W-1:0]       rsp_sum;
   logic               rsp_cout;
   logic               rsp_ovf;

   logic [SLICE_W:0]   addResult;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state: 0 idle, 1 running, 2 done
   int                mState = 0;
   int                mCount = 0;
   logic [W-1:0]      mA = '0;
   logic [W-1:0]      mB = '0;
   logic              mCin0 = 1'b0;
   logic [W-1:0]      mSum = '0;
   logic              mCout = 1'b0;
   logic              mOvf = 1'b0;
   logic [W-1:0]      pSum = '0;
   logic              pCout = 1'b0;
   logic              pOvf = 1'b0;

   serial_add_ctrl #(.SLICE_W(SLICE_W), .NUM_SLICES(NUM_SLICES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_sub   (req_sub),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf)
   );

   // External slice adder, purely combinational
   assign addResult = {1'b0, add_a} + {1'b0, add_b} + {{SLICE_W{1'b0}}, add_cin};
   assign add_s     = addResult[SLICE_W-1:0];
   assign add_cout  = addResult[SLICE_W];

   always #5 clk = ~clk;

   // Global watchdog so the bench always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Asynchronous reset clears the model immediately, as it does the design
   always @(negedge rst_n) begin
      mState = 0;
      mCount = 0;
      mSum   = '0;
      mCout  = 1'b0;
      mOvf   = 1'b0;
   end

   // Compare on every falling edge, then advance the model using the inputs the next rising edge will sample
   always @(negedge clk) begin
      longint unsigned mask;
      longint unsigned lo;
      logic [SLICE_W-1:0] expA;
      logic [SLICE_W-1:0] expB;
      logic               expCin;
      logic [63:0]        full;
      logic [W-1:0]       bEff;

      checkOutput("req_ready", {63'd0, req_ready}, {63'd0, (mState == 0)});
      checkOutput("busy", {63'd0, busy}, {63'd0, (mState == 1)});
      checkOutput("rsp_valid", {63'd0, rsp_valid}, {63'd0, (mState == 2)});
      expA = '0;
      expB = '0;
      expCin = 1'b0;
      if (mState == 1) begin
         expA   = SLICE_W'(mA >> (SLICE_W * mCount));
         expB   = SLICE_W'(mB >> (SLICE_W * mCount));
         mask   = (64'd1 << (SLICE_W * mCount)) - 64'd1;
         lo     = (64'(mA) & mask) + (64'(mB) & mask) + 64'(mCin0);
         expCin = lo[SLICE_W * mCount];
      end else begin
         checkOutput("rsp_sum", 64'(rsp_sum), 64'(mSum));
         checkOutput("rsp_cout", {63'd0, rsp_cout}, {63'd0, mCout});
         checkOutput("rsp_ovf", {63'd0, rsp_ovf}, {63'd0, mOvf});
      end
      checkOutput("add_a", 64'(add_a), 64'(expA));
      checkOutput("add_b", 64'(add_b), 64'(expB));
      checkOutput("add_cin", {63'd0, add_cin}, {63'd0, expCin});

      if (!rst_n) begin
         mState = 0;
         mCount = 0;
         mSum   = '0;
         mCout  = 1'b0;
         mOvf   = 1'b0;
      end else begin
         case (mState)
            0: if (req_valid) begin
               bEff   = req_sub ? ~req_b : req_b;
               mA     = req_a;
               mB     = bEff;
               mCin0  = req_sub ? 1'b1 : req_cin;
               full   = 64'(req_a) + 64'(bEff) + 64'(mCin0);
               pSum   = full[W-1:0];
               pCout  = full[W];
               pOvf   = (req_a[W-1] == bEff[W-1]) && (pSum[W-1] != req_a[W-1]);
               mCount = 0;
               mState = 1;
            end
            1: begin
               if (mCount == NUM_SLICES - 1) begin
                  mState = 2;
                  mSum   = pSum;
                  mCout  = pCout;
                  mOvf   = pOvf;
               end else begin
                  mCount++;
               end
            end
            default: if (rsp_ready) mState = 0;
         endcase
      end
   end

   // Present a request and wait (bounded) until it is accepted. After acceptance the request lines carry junk.
   task automatic issueReq(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      bit seen;
      seen = 0;
      req_a = a;
      req_b = b;
      req_cin = cin;
      req_sub = sub;
      req_valid = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (req_ready) begin
            seen = 1;
            break;
         end
      end
      if (!seen) checkOutput("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      req_a     = $urandom;
      req_b     = $urandom;
      req_cin   = 1'($urandom);
      req_sub   = 1'($urandom);
      req_valid = 1'($urandom);
   endtask

   // Wait for the response, optionally check literal values, apply backpressure, then handshake
   task automatic applyStimulus(input int hold, input bit checkLit,
                                input logic [W-1:0] eSum, input logic eCout, input logic eOvf,
                                input bit preNext, input logic [W-1:0] nA, input logic [W-1:0] nB,
                                input logic nCin, input logic nSub);
      bit seen;
      int busyCnt;
      seen = 0;
      busyCnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1;
            break;
         end
         if (busy) busyCnt++;
      end
      if (!seen) checkOutput("rsp_timeout", 64'd0, 64'd1);
      if (checkLit) begin
         checkOutput("lit_busy_cycles", 64'(busyCnt), 64'(NUM_SLICES));
         checkOutput("lit_sum", 64'(rsp_sum), 64'(eSum));
         checkOutput("lit_cout", {63'd0, rsp_cout}, {63'd0, eCout});
         checkOutput("lit_ovf", {63'd0, rsp_ovf}, {63'd0, eOvf});
      end
      @(posedge clk);
      #1;
      req_valid = preNext;
      if (preNext) begin
         req_a   = nA;
         req_b   = nB;
         req_cin = nCin;
         req_sub = nSub;
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[3] = '{32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0};
      vecs[4] = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
      vecs[5] = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[6] = '{32'h00000003, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};

      $display("[TB] start");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         issueReq(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         applyStimulus(i % 3, 1'b1, vecs[i].s, vecs[i].co, vecs[i].ov, 1'b0, '0, '0, 1'b0, 1'b0);
      end

      // Backpressure with a new request waiting during DONE
      issueReq(32'h12345678, 32'h11111111, 1'b0, 1'b0);
      applyStimulus(5, 1'b1, 32'h23456789, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h00000001, 1'b0, 1'b1);
      issueReq(32'h80000000, 32'h00000001, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

      // Reset asserted between edges while the third slice is in flight
      issueReq(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_add_a", 64'(add_a), 64'd0);
      checkOutput("rst_add_b", 64'(add_b), 64'd0);
      checkOutput("rst_add_cin", {63'd0, add_cin}, 64'd0);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
      issueReq(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
      applyStimulus(1, 1'b1, 32'h00010000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

      // Random operations against the model
      for (int r = 0; r < 30; r++) begin
         issueReq($urandom, $urandom, 1'($urandom), 1'($urandom));
         applyStimulus(int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
